// File: rtl/data_sram_if_if.sv
// SRAM-like split request/response data bus between the bridge and memory.
interface data_sram_if_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  // Bridge side: issues requests, receives handshakes and read data.
  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  // Memory side: accepts requests, returns handshakes and read data.
  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/data_sram_if.sv
// Data-side bridge: turns a mem-stage load/store into one split bus
// transaction, stalls the pipeline until the response, and holds the load
// word while another stall source keeps the pipeline frozen.
module data_sram_if #(
  parameter logic [31:0] PADDR_MASK = 32'h1FFF_FFFF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_en,
  input  logic          mem_wen,
  input  logic [3:0]    mem_sel,
  input  logic [31:0]   mem_addr,
  input  logic [31:0]   mem_wdata,
  input  logic          ext_stall,
  output logic [31:0]   mem_rdata,
  output logic          mem_stall,
  data_sram_if_if.master bus
);

  localparam int unsigned DataW = 32;
  localparam int unsigned SizeW = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } stateT;

  stateT             state;
  logic [DataW-1:0]  rdataHold;
  logic              reqActive;
  logic              busy;
  logic              capture;
  logic              issue;

  // Byte-enable pattern to transfer size; unexpected patterns fall back to word.
  function automatic logic [SizeW-1:0] sizeOf(input logic [3:0] sel);
    case (sel)
      4'b1111:                            sizeOf = SizeW'(2);
      4'b0011, 4'b1100:                   sizeOf = SizeW'(1);
      4'b0001, 4'b0010, 4'b0100, 4'b1000: sizeOf = SizeW'(0);
      default:                            sizeOf = SizeW'(2);
    endcase
  endfunction

  // Per-state request, busy and response-capture qualifiers.
  always_comb begin
    reqActive = 1'b0;
    busy      = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        reqActive = mem_en;
        busy      = mem_en;
        capture   = mem_en & bus.data_addr_ok & bus.data_data_ok;
      end
      REQ: begin
        reqActive = 1'b1;
        busy      = 1'b1;
        capture   = bus.data_addr_ok & bus.data_data_ok;
      end
      WAIT: begin
        busy    = 1'b1;
        capture = bus.data_data_ok;
      end
      default: begin
        reqActive = 1'b0;
      end
    endcase
  end

  // Pipeline-facing outputs; read data bypasses the register in the response cycle.
  always_comb begin
    issue     = rst & reqActive;
    mem_stall = rst & busy & ~capture;
    mem_rdata = rdataHold;
    if (!rst) begin
      mem_rdata = '0;
    end else if (capture) begin
      mem_rdata = bus.data_rdata;
    end
  end

  // Bus request fields follow the frozen mem-stage inputs while requesting.
  assign bus.data_req   = issue;
  assign bus.data_wr    = issue & mem_wen;
  assign bus.data_size  = issue ? sizeOf(mem_sel) : '0;
  assign bus.data_addr  = issue ? (mem_addr & PADDR_MASK) : '0;
  assign bus.data_wdata = issue ? mem_wdata : '0;

  // Transaction sequencing and load-word capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rdataHold <= '0;
    end else begin
      if (capture) begin
        rdataHold <= bus.data_rdata;
      end
      case (state)
        IDLE: begin
          if (mem_en) begin
            if (bus.data_addr_ok) begin
              state <= bus.data_data_ok ? DONE : WAIT;
            end else begin
              state <= REQ;
            end
          end
        end
        REQ: begin
          if (bus.data_addr_ok) begin
            state <= bus.data_data_ok ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (bus.data_data_ok) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (!ext_stall) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
